// File: rtl/uart_tx_sequencer_if.sv
// Peripheral register bus used by the UART TX sequencer.
// The master polls the status register and writes TX data bytes.
interface uart_tx_sequencer_if;
    logic [15:0] read_addr;
    logic [15:0] read_data;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_strobe;

    modport master (
        output read_addr,
        input  read_data,
        output write_addr,
        output write_data,
        output write_strobe
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  write_addr,
        input  write_data,
        input  write_strobe
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Two-requester round-robin sequencer that feeds bytes into a UART TX buffer,
// polling its fill level first and backing off while the buffer is full.
module uart_tx_sequencer #(
    parameter logic [15:0] BASE_ADDR      = 16'h8300,
    parameter logic [7:0]  TX_FIFO_DEPTH  = 8'd16,
    parameter logic [15:0] BACKOFF_CYCLES = 16'd64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req0_valid,
    input  logic                       i_req1_valid,
    input  logic [7:0]                 i_req0_data,
    input  logic [7:0]                 i_req1_data,
    output logic                       o_req0_ready,
    output logic                       o_req1_ready,
    uart_tx_sequencer_if.master        bus,
    output logic [1:0]                 o_grant,
    output logic                       o_busy,
    output logic [15:0]                o_bytes_sent,
    output logic [7:0]                 o_stall_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POLL    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_BACKOFF = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] boff_q, boff_d;
    logic [15:0] sent_q, sent_d;
    logic [7:0]  stall_q, stall_d;

    logic        owner_valid_s;
    logic        pick_s;
    logic [1:0]  owner_oh_s;
    logic        status_hi_unused_s;
    logic [15:0] rd_addr_s, wr_addr_s, wr_data_s;
    logic        wr_stb_s, rdy0_s, rdy1_s, busy_s;
    logic [1:0]  grant_s;

    // Only the low byte of the status word carries the fill level.
    assign status_hi_unused_s = ^bus.read_data[15:8];

    assign owner_valid_s = owner_q ? i_req1_valid : i_req0_valid;
    assign pick_s        = (i_req0_valid && i_req1_valid) ? ~last_q : i_req1_valid;
    assign owner_oh_s    = owner_q ? 2'b10 : 2'b01;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            byte_q  <= 8'h00;
            boff_q  <= 16'h0000;
            sent_q  <= 16'h0000;
            stall_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            boff_q  <= boff_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    // Next-state, arbitration and counter updates
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        byte_d  = byte_q;
        boff_d  = boff_q;
        sent_d  = sent_q;
        stall_d = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    state_d = ST_POLL;
                    owner_d = pick_s;
                    last_d  = pick_s;
                    byte_d  = pick_s ? i_req1_data : i_req0_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POLL: begin
                if (!owner_valid_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!owner_valid_s) begin
                    state_d = ST_IDLE;
                end else if (bus.read_data[7:0] < TX_FIFO_DEPTH) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_BACKOFF;
                    boff_d  = BACKOFF_CYCLES - 16'd1;
                    stall_d = (stall_q == 8'hFF) ? 8'hFF : (stall_q + 8'd1);
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                sent_d  = sent_q + 16'd1;
            end
            ST_BACKOFF: begin
                if (!owner_valid_s) begin
                    state_d = ST_IDLE;
                end else if (boff_q == 16'h0000) begin
                    state_d = ST_POLL;
                end else begin
                    boff_d = boff_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        rd_addr_s = 16'h0000;
        wr_addr_s = 16'h0000;
        wr_data_s = 16'h0000;
        wr_stb_s  = 1'b0;
        rdy0_s    = 1'b0;
        rdy1_s    = 1'b0;
        grant_s   = 2'b00;
        busy_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_POLL: begin
                busy_s    = 1'b1;
                grant_s   = owner_oh_s;
                rd_addr_s = BASE_ADDR;
            end
            ST_CHECK, ST_BACKOFF: begin
                busy_s  = 1'b1;
                grant_s = owner_oh_s;
            end
            ST_WRITE: begin
                busy_s    = 1'b1;
                grant_s   = owner_oh_s;
                wr_stb_s  = 1'b1;
                wr_addr_s = BASE_ADDR + 16'd2;
                wr_data_s = {8'h00, byte_q};
                rdy0_s    = ~owner_q;
                rdy1_s    = owner_q;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.read_addr    = rd_addr_s;
    assign bus.write_addr   = wr_addr_s;
    assign bus.write_data   = wr_data_s;
    assign bus.write_strobe = wr_stb_s;
    assign o_req0_ready     = rdy0_s;
    assign o_req1_ready     = rdy1_s;
    assign o_grant          = grant_s;
    assign o_busy           = busy_s;
    assign o_bytes_sent     = sent_q;
    assign o_stall_count    = stall_q;

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h8300: UART peripheral base address; status at +0 (TX fill level), TX data at +2.
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 8'd16: UART TX buffer capacity in bytes.
REQ-003 SHALL have parameter BACKOFF_CYCLES, default 16'd64: wait between status polls when the TX buffer is full; legal range 1..65535.
REQ-004 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports i_req0_valid / i_req1_valid, input, 1 each: requester has a byte pending.
REQ-007 SHALL have ports i_req0_data / i_req1_data, input, 8 each: pending byte, held stable while valid.
REQ-008 SHALL have ports o_req0_ready / o_req1_ready, output, 1 each: one-cycle pulse, byte accepted.
REQ-009 SHALL have port read_addr, output, 16: peripheral read address.
REQ-010 SHALL have port read_data, input, 16: peripheral read data, valid the cycle after read_addr is presented.
REQ-011 SHALL have ports write_addr (output, 16), write_data (output, 16), write_strobe (output, 1): peripheral write bus.
REQ-012 SHALL have port o_grant, output, 2: one-hot current owner; 2'b00 when none.
REQ-013 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have ports o_bytes_sent (output, 16, wrapping) and o_stall_count (output, 8, saturating at 8'hFF).

Function
REQ-015 SHALL implement states IDLE, POLL, CHECK, WRITE, BACKOFF.
REQ-016 IDLE: if any valid, SHALL latch grant and go to POLL next cycle; else SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-018 Grant SHALL stay locked from POLL until the return to IDLE; no re-arbitration during BACKOFF.
REQ-019 POLL: SHALL drive read_addr = BASE_ADDR+0 for exactly one cycle, then go to CHECK.
REQ-020 CHECK: SHALL sample read_data[7:0]; if value < TX_FIFO_DEPTH go to WRITE, else go to BACKOFF and increment o_stall_count (saturating).
REQ-021 WRITE: for exactly one cycle SHALL assert write_strobe with write_addr = BASE_ADDR+2, write_data = {8'h00, granted byte}, and the granted ready; SHALL increment o_bytes_sent; SHALL go to IDLE.
REQ-022 BACKOFF: SHALL load a counter with BACKOFF_CYCLES-1 on entry, decrement each cycle, and go to POLL in the cycle after it reaches 0 (BACKOFF_CYCLES cycles in BACKOFF).
REQ-023 If the granted valid deasserts in POLL, CHECK or BACKOFF, SHALL return to IDLE next cycle with no write and no ready; the last-grant pointer SHALL still advance.
REQ-024 Outside POLL, read_addr SHALL be 16'h0000; outside WRITE, write_addr, write_data and write_strobe SHALL all be 0.
REQ-025 Ready SHALL never be asserted to a non-granted requester, and never to both in one cycle.
REQ-026 Minimum byte-to-byte time with no stall SHALL be 4 cycles (IDLE, POLL, CHECK, WRITE).
REQ-027 Only bits [7:0] of read_data SHALL be used; bits [15:8] SHALL be ignored.

Reset
REQ-028 When i_rst_n is low, SHALL enter IDLE immediately (asynchronously) and set all outputs to 0: o_grant = 2'b00, counters = 0, ready = 0, buses = 0.
REQ-029 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first contention.
REQ-030 Reset asserted mid-WRITE SHALL drop write_strobe and ready in the same cycle, and the byte SHALL count as not sent.

Verification
REQ-031 Requester 0 valid with 8'h41, status reads 3 -> POLL at cycle 1, write_strobe at cycle 3 with write_addr 16'h8302, write_data 16'h0041, o_req0_ready pulse, o_bytes_sent = 1.
REQ-032 Both valid continuously, status 0 -> grants alternate 0,1,0,1; each ready pulse coincides with write_strobe; writes are 4 cycles apart.
REQ-033 Status reads 16 twice then 5, BACKOFF_CYCLES = 4 -> two BACKOFF periods of 4 cycles each, o_stall_count = 2, then one write.
REQ-034 Status reads 16 for 300 polls -> o_stall_count saturates at 8'hFF, with no write and no ready.
REQ-035 Requester 1 drops valid during BACKOFF -> return to IDLE with no write; next contention grants requester 0.
REQ-036 i_rst_n pulsed low during WRITE -> all outputs 0 within the reset assertion; o_bytes_sent = 0; operation resumes from IDLE after release.
